dds_sweep_ctrl: RTL and testbench

- Frequency-sweep sequencer that drives the DDS core's Fword, Pword and Model_sel inputs.
- Steps the 32-bit frequency control word from a start value towards a stop value, holding each point for a programmable dwell time.
- Supports single, sawtooth-repeat and triangle (up/down) sweeps.
- Sits between the register/control logic and the DDS core, in the DDS clock domain.

---
 rtl/dds_sweep_ctrl.sv | 145 ++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer feeding the DDS core's Fword/Pword/Model_sel.
// Steps Fword from F_start to F_stop by F_step, holding each point Dwell+1
// cycles; single, sawtooth-repeat and triangle sweeps. All outputs registered.
module dds_sweep_ctrl #(
  parameter int FW_W    = 32,
  parameter int PW_W    = 12,
  parameter int DWELL_W = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Abort,
  input  logic [FW_W-1:0]    F_start,
  input  logic [FW_W-1:0]    F_stop,
  input  logic [FW_W-1:0]    F_step,
  input  logic [DWELL_W-1:0] Dwell,
  input  logic [1:0]         Sweep_mode,
  input  logic [1:0]         Wave_sel,
  input  logic [PW_W-1:0]    Pword_in,
  output logic [FW_W-1:0]    Fword,
  output logic [PW_W-1:0]    Pword,
  output logic [1:0]         Model_sel,
  output logic               Busy,
  output logic               Done,
  output logic               Sweep_wrap,
  output logic               Cfg_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_SAW = 2'b01;
  localparam logic [1:0] M_TRI = 2'b10;

  logic [0:0]         state;
  logic               dir_dn;
  logic [DWELL_W-1:0] cnt;

  // configuration captured on an accepted Start
  logic [FW_W-1:0]    f_start_q;
  logic [FW_W-1:0]    f_stop_q;
  logic [FW_W-1:0]    f_step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [1:0]         mode_q;

  logic [FW_W:0]      up_sum;
  logic [FW_W:0]      dn_diff;
  logic [FW_W-1:0]    up_next;
  logic [FW_W-1:0]    dn_next;
  logic               cfg_ok;

  // next point candidates, one extra bit so overflow/underflow clamps instead of wrapping
  always_comb begin
    up_sum  = {1'b0, Fword} + {1'b0, f_step_q};
    dn_diff = {1'b0, Fword} - {1'b0, f_step_q};
    up_next = (up_sum > {1'b0, f_stop_q}) ? f_stop_q : up_sum[FW_W-1:0];
    dn_next = (dn_diff[FW_W] || (dn_diff[FW_W-1:0] < f_start_q)) ? f_start_q
                                                                  : dn_diff[FW_W-1:0];
    cfg_ok  = (F_step != '0) && (F_stop >= F_start);
  end

  // sweep sequencer: start/abort handling, dwell countdown and point stepping
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_IDLE;
      dir_dn     <= 1'b0;
      cnt        <= '0;
      Fword      <= '0;
      Pword      <= '0;
      Model_sel  <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Sweep_wrap <= 1'b0;
      Cfg_err    <= 1'b0;
      f_start_q  <= '0;
      f_stop_q   <= '0;
      f_step_q   <= '0;
      dwell_q    <= '0;
      mode_q     <= '0;
    end else begin
      Done       <= 1'b0;
      Sweep_wrap <= 1'b0;
      Cfg_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          // Abort alongside Start suppresses the request entirely
          if (Start && !Abort) begin
            if (cfg_ok) begin
              f_start_q <= F_start;
              f_stop_q  <= F_stop;
              f_step_q  <= F_step;
              dwell_q   <= Dwell;
              mode_q    <= Sweep_mode;
              Fword     <= F_start;
              Pword     <= Pword_in;
              Model_sel <= Wave_sel;
              cnt       <= Dwell;
              dir_dn    <= 1'b0;
              Busy      <= 1'b1;
              state     <= S_RUN;
            end else begin
              Cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          if (Abort) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt <= dwell_q;
            if (!dir_dn) begin
              if (Fword != f_stop_q) begin
                Fword <= up_next;
              end else if (mode_q == M_SAW) begin
                Fword      <= f_start_q;
                Sweep_wrap <= 1'b1;
              end else if (mode_q == M_TRI) begin
                dir_dn     <= 1'b1;
                Fword      <= dn_next;
                Sweep_wrap <= 1'b1;
              end else begin
                // single sweep (mode 11 included): park on F_stop
                state <= S_IDLE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end
            end else begin
              if (Fword != f_start_q) begin
                Fword <= dn_next;
              end else begin
                dir_dn     <= 1'b0;
                Fword      <= up_next;
                Sweep_wrap <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: stimulus pushes per-cycle expectations
// built from point lists; a negedge monitor pops and compares.
module tb_dds_sweep_ctrl;

  logic        Clk, Reset, Start, Abort;
  logic [31:0] F_start, F_stop, F_step;
  logic [15:0] Dwell;
  logic [1:0]  Sweep_mode, Wave_sel;
  logic [11:0] Pword_in;
  logic [31:0] Fword;
  logic [11:0] Pword;
  logic [1:0]  Model_sel;
  logic        Busy, Done, Sweep_wrap, Cfg_err;

  dds_sweep_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort),
    .F_start(F_start), .F_stop(F_stop), .F_step(F_step), .Dwell(Dwell),
    .Sweep_mode(Sweep_mode), .Wave_sel(Wave_sel), .Pword_in(Pword_in),
    .Fword(Fword), .Pword(Pword), .Model_sel(Model_sel),
    .Busy(Busy), .Done(Done), .Sweep_wrap(Sweep_wrap), .Cfg_err(Cfg_err)
  );

  typedef struct packed {
    logic [31:0] v;
    logic        w;
  } pt_t;
  typedef pt_t pt_q_t[$];

  typedef struct {
    int          tag;
    logic [31:0] fw;
    logic [11:0] pw;
    logic [1:0]  ms;
    logic        busy, done, wrap, cerr;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] h_fw = 0;
  logic [11:0] h_pw = 0;
  logic [1:0]  h_ms = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, a, e);
  endtask

  // monitor: compare DUT outputs against the expectation tagged for this cycle
  always @(negedge Clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
      e = exp_q.pop_front();
      chk("stale_expect", 32'(e.tag), 32'(cyc));
    end
    if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
      e = exp_q.pop_front();
      chk("fword", Fword, e.fw);
      chk("pword", 32'(Pword), 32'(e.pw));
      chk("model_sel", 32'(Model_sel), 32'(e.ms));
      chk("busy", 32'(Busy), 32'(e.busy));
      chk("done", 32'(Done), 32'(e.done));
      chk("sweep_wrap", 32'(Sweep_wrap), 32'(e.wrap));
      chk("cfg_err", 32'(Cfg_err), 32'(e.cerr));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_next(input logic [31:0] fw, input logic [11:0] pw, input logic [1:0] ms,
                             input logic busy, input logic done, input logic wrap, input logic cerr);
    exp_t e;
    e.tag = cyc + 1; e.fw = fw; e.pw = pw; e.ms = ms;
    e.busy = busy; e.done = done; e.wrap = wrap; e.cerr = cerr;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    Start = 0; Abort = 0;
    expect_next(h_fw, h_pw, h_ms, 0, 0, 0, 0);
    tick();
  endtask

  task automatic scramble();
    F_start = $urandom; F_stop = $urandom; F_step = $urandom_range(0, 3);
    Dwell = 16'($urandom); Sweep_mode = 2'($urandom); Wave_sel = 2'($urandom);
    Pword_in = 12'($urandom);
  endtask

  // point sequence of a sweep: up-leg list, down-leg list, repeated per mode
  function automatic void gen_points(input logic [1:0] mode, input longint s, input longint p,
                                     input longint st, input int need, output pt_q_t q);
    longint u[$];
    longint d[$];
    longint v;
    v = s; u.push_back(v);
    while (v != p) begin v = v + st; if (v > p) v = p; u.push_back(v); end
    v = p; d.push_back(v);
    while (v != s) begin v = v - st; if (v < s) v = s; d.push_back(v); end
    q = {};
    foreach (u[i]) q.push_back({u[i][31:0], 1'b0});
    if (mode == 2'b01) begin
      while (q.size() < need)
        foreach (u[i]) q.push_back({u[i][31:0], i == 0});
    end else if (mode == 2'b10) begin
      while (q.size() < need) begin
        if (d.size() == 1) q.push_back({d[0][31:0], 1'b1});
        else for (int i = 1; i < d.size(); i++) q.push_back({d[i][31:0], i == 1});
        if (u.size() == 1) q.push_back({u[0][31:0], 1'b1});
        else for (int i = 1; i < u.size(); i++) q.push_back({u[i][31:0], i == 1});
      end
    end
  endfunction

  task automatic sweep(input logic [1:0] mode, input logic [31:0] fs, input logic [31:0] fp,
                       input logic [31:0] st, input logic [15:0] dw, input logic [11:0] pw,
                       input logic [1:0] ws, input int abort_at, input int start_at,
                       input int reset_at, input int max_cyc);
    pt_q_t pts;
    pt_t   tr[$];
    bit    ok;
    F_start = fs; F_stop = fp; F_step = st; Dwell = dw; Sweep_mode = mode;
    Wave_sel = ws; Pword_in = pw; Start = 1; Abort = 0;
    ok = (st != 0) && (fp >= fs);
    if (!ok) begin
      expect_next(h_fw, h_pw, h_ms, 0, 0, 0, 1);
      tick();
      Start = 0;
      idle_cycle();
      return;
    end
    expect_next(fs, pw, ws, 1, 0, 0, 0);
    h_pw = pw; h_ms = ws;
    tick();
    Start = 0;
    scramble();
    gen_points(mode, longint'(fs), longint'(fp), longint'(st), max_cyc / (int'(dw) + 1) + 2, pts);
    foreach (pts[i])
      for (int j = 0; j <= int'(dw); j++) tr.push_back({pts[i].v, pts[i].w && (j == 0)});
    for (int k = 1; k < 5000; k++) begin
      if (k >= tr.size()) begin
        expect_next(fp, h_pw, h_ms, 0, 1, 0, 0);
        h_fw = fp;
        tick();
        idle_cycle();
        return;
      end
      if (k == reset_at) begin
        Reset = 1;
        expect_next(0, 0, 0, 0, 0, 0, 0);
        h_fw = 0; h_pw = 0; h_ms = 0;
        tick();
        Reset = 0;
        idle_cycle();
        return;
      end
      if (k == abort_at) begin
        Abort = 1;
        expect_next(tr[k-1].v, h_pw, h_ms, 0, 0, 0, 0);
        h_fw = tr[k-1].v;
        tick();
        Abort = 0;
        idle_cycle();
        return;
      end
      if (k == start_at) begin
        scramble();
        Start = 1;
      end
      expect_next(tr[k].v, h_pw, h_ms, 1, 0, tr[k].w, 0);
      tick();
      Start = 0;
    end
    chk("sweep_bound", 32'(tr.size()), 32'(5000));
  endtask

  initial begin
    int          span, r, ab, sa, rs, mx;
    logic [31:0] fs, fp, st;
    logic [1:0]  md;
    logic [15:0] dw;
    Reset = 1; Start = 0; Abort = 0;
    F_start = 0; F_stop = 0; F_step = 0; Dwell = 0;
    Sweep_mode = 0; Wave_sel = 0; Pword_in = 0;
    expect_next(0, 0, 0, 0, 0, 0, 0);
    tick();
    Reset = 0;
    idle_cycle();

    // directed
    sweep(2'b00, 100, 260, 50, 2, 12'h123, 2'd1, -1, -1, -1, 0);
    sweep(2'b00, 100, 260, 50, 2, 12'h0AA, 2'd2, 8, 5, -1, 0);
    sweep(2'b10, 0, 100, 40, 0, 12'h001, 2'd3, 20, -1, -1, 25);
    sweep(2'b01, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 1, 12'hFFF, 2'd0, 12, -1, -1, 15);
    sweep(2'b00, 100, 50, 10, 1, 12'h555, 2'd1, -1, -1, -1, 0);
    sweep(2'b00, 100, 200, 0, 1, 12'h555, 2'd1, -1, -1, -1, 0);
    sweep(2'b00, 100, 260, 50, 2, 12'h321, 2'd2, -1, -1, 6, 0);
    sweep(2'b00, 100, 260, 50, 2, 12'h321, 2'd2, -1, -1, -1, 0);
    // Start with Abort in IDLE: ignored, even with a bad config
    F_start = 100; F_stop = 50; F_step = 0; Start = 1; Abort = 1;
    expect_next(h_fw, h_pw, h_ms, 0, 0, 0, 0);
    tick();
    idle_cycle();
    sweep(2'b00, 77, 77, 5, 1, 12'h077, 2'd1, -1, -1, -1, 0);
    sweep(2'b10, 77, 77, 5, 1, 12'h078, 2'd2, 9, -1, -1, 10);
    sweep(2'b01, 77, 77, 5, 0, 12'h079, 2'd3, 6, -1, -1, 7);
    sweep(2'b11, 10, 40, 15, 0, 12'h07A, 2'd0, -1, -1, -1, 0);

    // randomized
    for (int n = 0; n < 40; n++) begin
      span = $urandom_range(0, 1000);
      st = $urandom_range(span / 8 + 1, span + 50);
      fs = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'(span) : 32'($urandom_range(0, 100000));
      fp = fs + 32'(span);
      r = $urandom_range(0, 9);
      if (r == 0) st = 0;
      else if (r == 1 && fs != 0) fp = fs - 1;
      md = 2'($urandom);
      dw = 16'($urandom_range(0, 3));
      rs = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : -1;
      sa = $urandom_range(1, 30);
      if (md == 2'b01 || md == 2'b10) begin
        ab = $urandom_range(2, 40);
        mx = ab;
      end else begin
        ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
        mx = 0;
      end
      sweep(md, fs, fp, st, dw, 12'($urandom), 2'($urandom), ab, sa, rs, mx);
    end

    repeat (4) idle_cycle();
    repeat (3) tick();
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
